// File: rtl/source_inverse_solver_if.sv
// rtl/source_inverse_solver_if.sv - request/result bundle for the inverse search engine
interface source_inverse_solver_if;
    logic       start;
    logic [1:0] in_a;
    logic [1:0] in_c;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] match_mask;
    logic [2:0] match_count;
    logic [1:0] first_b;

    modport master (
        output start, in_a, in_c,
        input  busy, done, found, match_mask, match_count, first_b
    );

    modport slave (
        input  start, in_a, in_c,
        output busy, done, found, match_mask, match_count, first_b
    );
endinterface

// File: rtl/source_inverse_solver.sv
// rtl/source_inverse_solver.sv - finds every b with F(a, b) == c by scanning b = 0..3
module source_inverse_solver #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    source_inverse_solver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] a_q, a_d;
    logic [1:0] c_q, c_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] count_q, count_d;
    logic       found_q, found_d;
    logic [1:0] first_q, first_d;
    logic       hit;

    // Local copy of the forward mapping c = F(a, b), returned as {c1, c0}.
    function automatic logic [1:0] f_map(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] c;
        case (a)
            2'b00:   c = (b == 2'b11) ? 2'b11 : 2'b00;
            2'b01:   c = {b[1], 1'b1};
            default: c = {~b[1], b[1]};
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        c_d     = c_q;
        mask_d  = mask_q;
        count_d = count_q;
        found_d = found_q;
        first_d = first_q;
        hit     = (f_map(a_q, idx_q) == c_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in_a;
                    c_d     = bus.in_c;
                    mask_d  = 4'b0000;
                    count_d = 3'd0;
                    found_d = 1'b0;
                    first_d = 2'd0;
                    idx_d   = 2'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    mask_d[idx_q] = 1'b1;
                    count_d       = count_q + 3'd1;
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = idx_q;
                    end
                end
                // The idx == 3 exit keeps the 2-bit index from wrapping.
                if (EARLY_EXIT && hit) begin
                    state_d = DONE;
                end else if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            a_q     <= 2'd0;
            c_q     <= 2'd0;
            mask_q  <= 4'b0000;
            count_q <= 3'd0;
            found_q <= 1'b0;
            first_q <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            c_q     <= c_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            found_q <= found_d;
            first_q <= first_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.found       = found_q;
    assign bus.match_mask  = mask_q;
    assign bus.match_count = count_q;
    assign bus.first_b     = first_q;

endmodule

// File: tb/tb_source_inverse_solver.sv
// tb/tb_source_inverse_solver.sv - scoreboard bench driving a full-scan and an early-exit instance
module tb_source_inverse_solver;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       found;
        logic [1:0] first;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] in_a = 2'd0;
    logic [1:0] in_c = 2'd0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0;
    exp_t last1;

    source_inverse_solver_if if0 ();
    source_inverse_solver_if if1 ();

    assign if0.start = start;
    assign if0.in_a  = in_a;
    assign if0.in_c  = in_c;
    assign if1.start = start;
    assign if1.in_a  = in_a;
    assign if1.in_c  = in_c;

    source_inverse_solver #(.EARLY_EXIT(1'b0)) dut_full  (.clk(clk), .rst_n(rst_n), .bus(if0));
    source_inverse_solver #(.EARLY_EXIT(1'b1)) dut_early (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the forward mapping written straight from its rules.
    function automatic logic [1:0] fwd(input int a, input int b);
        int b1;
        b1 = (b >= 2) ? 1 : 0;
        if (a == 0)      return (b == 3) ? 2'd3 : 2'd0;
        else if (a == 1) return 2'((b1 * 2) + 1);
        else             return 2'(((1 - b1) * 2) + b1);
    endfunction

    function automatic exp_t model(input int a, input int c, input bit ee, input int k);
        exp_t e;
        int   last;
        bit   stop;
        e.mask = 4'b0; e.cnt = 3'd0; e.found = 1'b0; e.first = 2'd0;
        last = 0; stop = 0;
        for (int b = 0; b < 4; b++) begin
            if (!stop) begin
                last = b;
                if (fwd(a, b) == 2'(c)) begin
                    e.mask[b] = 1'b1;
                    e.cnt     = e.cnt + 3'd1;
                    if (!e.found) begin
                        e.found = 1'b1;
                        e.first = 2'(b);
                    end
                    if (ee) stop = 1;
                end
            end
        end
        e.cyc = k + 1 + last;
        return e;
    endfunction

    task automatic cmp_result(input string tag, input exp_t e, input logic [3:0] m,
                              input logic [2:0] n, input logic f, input logic [1:0] fb);
        chk({tag, "_mask"},  int'(m),  int'(e.mask));
        chk({tag, "_count"}, int'(n),  int'(e.cnt));
        chk({tag, "_found"}, int'(f),  int'(e.found));
        chk({tag, "_first"}, int'(fb), int'(e.first));
    endtask

    task automatic monitor(input int sel);
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sel == 0 && if0.done) begin
                    if (q0.size() == 0) chk("full_spurious_done", 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("full_done_cycle", cyc, e.cyc);
                        cmp_result("full", e, if0.match_mask, if0.match_count, if0.found, if0.first_b);
                    end
                end
                if (sel == 1 && if1.done) begin
                    if (q1.size() == 0) chk("early_spurious_done", 1, 0);
                    else begin
                        e = q1.pop_front();
                        chk("early_done_cycle", cyc, e.cyc);
                        cmp_result("early", e, if1.match_mask, if1.match_count, if1.found, if1.first_b);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy0"},  int'(if0.busy), 0);
        chk({tag, "_done0"},  int'(if0.done), 0);
        cmp_result({tag, "_full"}, '{0, 4'b0, 3'd0, 1'b0, 2'd0},
                   if0.match_mask, if0.match_count, if0.found, if0.first_b);
        chk({tag, "_busy1"},  int'(if1.busy), 0);
        chk({tag, "_done1"},  int'(if1.done), 0);
        cmp_result({tag, "_early"}, '{0, 4'b0, 3'd0, 1'b0, 2'd0},
                   if1.match_mask, if1.match_count, if1.found, if1.first_b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((if0.busy || if1.busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (if0.busy || if1.busy) chk("idle_timeout", 1, 0);
    endtask

    // One request to both instances; perturb re-drives start at k+2 and scrambles the operands.
    task automatic do_op(input int a, input int c, input bit perturb);
        int k;
        @(negedge clk);
        in_a  = 2'(a);
        in_c  = 2'(c);
        start = 1'b1;
        k = cyc + 1;
        last0 = model(a, c, 1'b0, k);
        last1 = model(a, c, 1'b1, k);
        q0.push_back(last0);
        q1.push_back(last1);
        @(negedge clk);
        start = 1'b0;
        if (perturb) begin
            in_a  = 2'($urandom_range(0, 3));
            in_c  = 2'($urandom_range(0, 3));
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        @(negedge clk);
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        cmp_result("hold_full", last0, if0.match_mask, if0.match_count, if0.found, if0.first_b);
        cmp_result("hold_early", last1, if1.match_mask, if1.match_count, if1.found, if1.first_b);
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        do_op(1, 3, 0);
        do_op(0, 0, 0);
        do_op(2, 3, 0);
        do_op(3, 1, 0);
        do_op(0, 3, 0);
        do_op(1, 1, 0);
        do_op(1, 3, 1);
        do_op(0, 0, 1);
        do_op(1, 1, 1);

        // Reset mid-scan on an operand pair with no match, so both are still scanning.
        @(negedge clk);
        in_a = 2'd2; in_c = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3, 1, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/source_inverse_solver.md
Name: source_inverse_solver

Overview:
- Inverse of the team's 2-bit combinational mapping c = F(a, b).
- Given an observed code c and the known operand a, finds every operand b that produces c.
- Sequential search engine: scans candidates b = 0..3 one per clock against an internal copy of F.
- Reports a match mask, match count, first match and found flag through a start/done handshake.
- Sits beside the forward block in the lab datapath as its decoding end.

Parameters:
EARLY_EXIT, 0, 1 = stop the scan at the first matching candidate; 0 = scan all four candidates.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
in_a  input  2  known operand a; captured on the accepted start.
in_c  input  2  observed code c; captured on the accepted start.
busy  output  1  high while state != IDLE.
done  output  1  single-cycle pulse; results valid from this cycle on.
found  output  1  at least one candidate matched.
match_mask  output  4  bit i set when F(a, i) == c.
match_count  output  3  popcount of match_mask, range 0..4.
first_b  output  2  lowest matching candidate; 0 when found = 0.

Behaviour:
- F, written {c1, c0}:
  - a = 00: c = 11 if b = 11, else c = 00.
  - a = 01: c0 = 1, c1 = b1.
  - a = 1x: c0 = b1, c1 = ~b1.
- Implement F as an internal combinational function of the captured a_r and candidate idx.
- Reset (async, rst_n = 0):
  - State IDLE.
  - busy, done, found, match_mask, match_count, first_b, idx, a_r, c_r all 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On a clock edge with start = 1: capture a_r = in_a, c_r = in_c.
  - Same edge: clear mask, count, found, first_b; set idx = 0; go to SCAN.
- SCAN: each edge evaluates hit = (F(a_r, idx) == c_r).
  - On hit: set match_mask[idx], increment match_count.
  - On hit with found = 0: set found = 1, first_b = idx.
  - EARLY_EXIT = 1 and hit: go to DONE.
  - Else if idx == 3: go to DONE.
  - Else: idx = idx + 1.
  - idx is 2 bits; idx never wraps because the idx == 3 exit takes priority.
- DONE: done = 1 for exactly this one cycle, then go to IDLE.
- Latency, with start accepted at edge k:
  - Full scan: done high in the cycle after edge k+4; busy high from edge k to edge k+5.
  - EARLY_EXIT with first match at idx m: done high in the cycle after edge k+1+m.
- Result outputs hold their values after DONE until the next accepted start clears them.
- start while busy: ignored; no effect on the in-flight scan or the captured operands.
- start in the same cycle done is high: ignored; the start must be reissued in IDLE.
- in_a and in_c changing during a scan: no effect (operands are captured).
- rst_n asserted mid-scan: immediate return to IDLE with all outputs 0; no done pulse.
- match_count == popcount(match_mask) at all times.
- first_b == index of the lowest set bit of match_mask when found = 1.

Test Plan:
- Reset with rst_n = 0, then release -> all outputs 0, busy = 0.
- a = 01, c = 11, EARLY_EXIT = 0 -> done at k+5.
  - Expect mask 1100, count 2, first_b 2, found 1.
- a = 00, c = 00 -> mask 0111, count 3, first_b 0.
- a = 10, c = 11 -> mask 0000, count 0, found 0, first_b 0.
- a = 11, c = 01 -> mask 1100, count 2, first_b 2.
- EARLY_EXIT = 1, a = 00, c = 11 -> done one cycle after edge k+4; mask 1000, count 1, first_b 3.
- Repeat with a = 01, c = 01 -> done one cycle after edge k+1; mask 0001, count 1.
- Extra start pulse at k+2 -> ignored.
- Change in_a and in_c during the scan -> results reflect the captured operands only.
- rst_n low at k+2 -> outputs 0 immediately, no done pulse.
  - Next start then completes normally.
